fetch_line_responder: RTL and testbench
=======================================

Name: fetch_line_responder

Overview:
- Instruction-side responder for the fetch stage.
- Accepts the fetch stage's pc every cycle and returns the instruction word for that pc from a single-line fetch buffer.
- On a buffer miss it stalls fetch, refills the whole line from backing instruction memory over a req/ack handshake, then serves the word.
- Sits between the fetch stage pc output / instruction data input and the instruction memory port.

Parameters:
- WIDTH, 32, data/address width.
- LINE_WORDS, 4, words per line; power of 2, >= 2.
- NOP_INSTR, 32'h00000013, word driven on instrdata while not hitting (addi x0,x0,0).

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- pc  input  WIDTH  fetch address from fetch stage; pc[1:0] ignored.
- instrdata  output  WIDTH  instruction for current pc (combinational from buffer).
- instr_valid  output  1  instrdata is the real word for pc this cycle.
- fetchstall  output  1  equals ~instr_valid; fetch must hold pc and the IF register.
- invalidate  input  1  fence.i/flush pulse; drops the line.
- mem_req  output  1  registered request to instruction memory.
- mem_addr  output  WIDTH  word address of request, word aligned.
- mem_rdata  input  WIDTH  memory read data, valid when mem_ack=1.
- mem_ack  input  1  memory accepts/returns word this cycle; sampled only while mem_req=1.

Behaviour:
- LB = log2(LINE_WORDS)+2. The line tag is pc[WIDTH-1:LB] and the word index is pc[LB-1:2].
- hit = line_valid && !filling && tag == pc[WIDTH-1:LB].
- On hit: instrdata = buf[pc[LB-1:2]] and instr_valid = 1, in the same cycle (0-cycle latency).
- Otherwise: instrdata = NOP_INSTR and instr_valid = 0.
- FSM has 2 states: IDLE and FILL.
- IDLE, no hit, invalidate=0:
  - Next cycle: state FILL.
  - fill_base latches {pc[WIDTH-1:LB], LB'b0}.
  - line_valid cleared, cnt = 0, mem_req = 1, mem_addr = fill_base.
- FILL, mem_ack=1:
  - buf[cnt] <= mem_rdata.
  - If cnt != LINE_WORDS-1: cnt++ and mem_addr += 4 the next cycle. mem_req stays 1 (back-to-back words allowed, one per ack).
  - If cnt == LINE_WORDS-1: tag <= fill_base tag, line_valid <= ~flush_pend, mem_req <= 0, state IDLE, flush_pend cleared.
- FILL, mem_ack=0: mem_req and mem_addr are held stable.
- Minimum miss penalty is LINE_WORDS+1 cycles from the miss cycle to the first hit cycle, with ack tied high.
- pc may change during FILL. The fill always completes for the latched line and is never aborted. A new miss is evaluated in IDLE after completion.
- Fill is always from word 0 upward; there is no critical-word-first.
- invalidate in IDLE: line_valid <= 0 next cycle. A miss in the same cycle is still started.
- invalidate in FILL: flush_pend <= 1. The completed line is installed invalid, so the next cycle re-misses and refills.
- invalidate and hit in the same cycle: the word is still served this cycle and the line is invalid from the next cycle.
- Address wrap: mem_addr increments modulo 2^WIDTH. A line never crosses the tag boundary because fills are aligned.
- Reset mid-fill: reset dominates; in-flight acks are ignored.
- Reset values:
  - state=IDLE, line_valid=0, flush_pend=0, cnt=0, mem_req=0, mem_addr=0, tag=0.
  - buf contents are don't-care.
  - Outputs after reset: instr_valid=0, fetchstall=1, instrdata=NOP_INSTR.

Optional Feature:
- Macro FETCH_PERF_COUNT_EN.
- When defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0], both reset to 0.
  - hit_count increments each cycle with instr_valid=1.
  - miss_count increments once per IDLE->FILL transition.
  - Both counters saturate at 32'hFFFFFFFF.
- When undefined: the ports and counters are absent and the rest of the behaviour is identical.

Test Plan:
- Reset, then pc=0x00000000 held, LINE_WORDS=4, mem_ack=1 every cycle, mem_rdata=0xA0000000|addr -> mem_addr 0x0,0x4,0x8,0xC on consecutive cycles; instrdata=0x13 and stall=1 for 5 cycles; then instrdata=0xA0000000, instr_valid=1.
- After the fill, pc steps 0x4,0x8,0xC -> 0xA0000004, 0xA0000008, 0xA000000C with no stall and mem_req=0.
- pc=0x10 -> miss; mem_ack toggles 1,0,1,0... -> mem_addr held stable on no-ack cycles; 4 words written; hit on 0x10 the cycle after the 4th ack.
- invalidate pulsed on the 2nd FILL cycle of the line 0x20 fill -> fill completes, line installed invalid, immediate refill of 0x20 (mem_addr 0x20 again), then hit.
- reset asserted on the 3rd FILL cycle -> next cycle mem_req=0, instr_valid=0; the previously held line misses again after reset.
- With FETCH_PERF_COUNT_EN defined: the first two scenarios -> miss_count=1, hit_count=4.

Source files
------------

// File: rtl/fetch_line_responder.sv
// Single-line instruction fetch buffer: serves the fetch pc with zero latency on a hit and
// refills the whole aligned line over a req/ack port on a miss. Optional macro: FETCH_PERF_COUNT_EN.
module fetch_line_responder #(
  parameter int unsigned      WIDTH      = 32,
  parameter int unsigned      LINE_WORDS = 4,
  parameter logic [WIDTH-1:0] NOP_INSTR  = WIDTH'(32'h0000_0013)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] instrdata,
  output logic             instr_valid,
  output logic             fetchstall,
  input  logic             invalidate,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack
`ifdef FETCH_PERF_COUNT_EN
  ,
  output logic [31:0]      hit_count,
  output logic [31:0]      miss_count
`endif
);

  localparam int unsigned IDX_W = $clog2(LINE_WORDS);
  localparam int unsigned LB    = IDX_W + 2;
  localparam int unsigned TAG_W = WIDTH - LB;

  typedef enum logic {
    S_IDLE,
    S_FILL
  } state_t;

  state_t             state_q;
  logic               line_valid_q;
  logic               flush_pend_q;
  logic [IDX_W-1:0]   cnt_q;
  logic               mem_req_q;
  logic [WIDTH-1:0]   mem_addr_q;
  logic [TAG_W-1:0]   tag_q;
  logic [TAG_W-1:0]   fill_tag_q;
  logic [WIDTH-1:0]   buf_q [LINE_WORDS];

  logic [TAG_W-1:0]   pc_tag;
  logic [IDX_W-1:0]   pc_idx;
  logic               hit;
  logic               last_word;
  logic               unused_pc_lsb;

  assign pc_tag        = pc[WIDTH-1:LB];
  assign pc_idx        = pc[LB-1:2];
  assign unused_pc_lsb = ^pc[1:0];

  assign hit       = line_valid_q && (state_q == S_IDLE) && (tag_q == pc_tag);
  assign last_word = (cnt_q == IDX_W'(LINE_WORDS - 1));

  assign instr_valid = hit;
  assign fetchstall  = ~hit;
  assign instrdata   = hit ? buf_q[pc_idx] : NOP_INSTR;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      line_valid_q <= 1'b0;
      flush_pend_q <= 1'b0;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      tag_q        <= '0;
      fill_tag_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (invalidate) line_valid_q <= 1'b0;
          if (!hit) begin
            state_q      <= S_FILL;
            fill_tag_q   <= pc_tag;
            line_valid_q <= 1'b0;
            flush_pend_q <= 1'b0;
            cnt_q        <= '0;
            mem_req_q    <= 1'b1;
            mem_addr_q   <= {pc_tag, {LB{1'b0}}};
          end
        end
        S_FILL: begin
          if (invalidate) flush_pend_q <= 1'b1;
          if (mem_ack) begin
            if (last_word) begin
              // An invalidate arriving on the final ack must also leave the line invalid.
              tag_q        <= fill_tag_q;
              line_valid_q <= ~(flush_pend_q | invalidate);
              flush_pend_q <= 1'b0;
              mem_req_q    <= 1'b0;
              state_q      <= S_IDLE;
            end else begin
              cnt_q      <= cnt_q + IDX_W'(1);
              mem_addr_q <= mem_addr_q + WIDTH'(4);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Line storage carries no reset; reset only blocks writes from in-flight acks.
  always_ff @(posedge clk) begin
    if (!reset && (state_q == S_FILL) && mem_ack) begin
      buf_q[cnt_q] <= mem_rdata;
    end
  end

`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] hit_count_q;
  logic [31:0] miss_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if (hit && (hit_count_q != 32'hFFFF_FFFF)) hit_count_q <= hit_count_q + 32'd1;
      if ((state_q == S_IDLE) && !hit && (miss_count_q != 32'hFFFF_FFFF))
        miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_fetch_line_responder.sv
// Directed bench for fetch_line_responder with a line-level reference model checked every cycle.
module tb_fetch_line_responder;
  localparam int          LW         = 4;
  localparam logic [31:0] LINE_MASK  = 32'hFFFF_FFF0;
  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [31:0] DATA_TAG   = 32'hA000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = '0;
  logic        invalidate = 1'b0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata;
  logic [31:0] instrdata;
  logic        instr_valid;
  logic        fetchstall;
  logic        mem_req;
  logic [31:0] mem_addr;
`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mem_rdata = DATA_TAG | mem_addr;

  fetch_line_responder dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .instrdata  (instrdata),
    .instr_valid(instr_valid),
    .fetchstall (fetchstall),
    .invalidate (invalidate),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
`ifdef FETCH_PERF_COUNT_EN
    .hit_count  (hit_count),
    .miss_count (miss_count),
`endif
    .mem_ack    (mem_ack)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one installed line (base address + words) and one outstanding fill.
  bit          m_valid = 0;
  bit          m_busy  = 0;
  bit          m_flush = 0;
  logic [31:0] m_line_base = '0;
  logic [31:0] m_fill_base = '0;
  int          m_got = 0;
  logic [31:0] m_words [LW];
  int unsigned m_hits = 0;
  int unsigned m_misses = 0;
  bit          cmp_en = 0;

  function automatic bit model_hit(input logic [31:0] a);
    return m_valid && !m_busy && ((a & LINE_MASK) == m_line_base);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 0; m_busy = 0; m_flush = 0; m_line_base = '0;
      m_hits = 0; m_misses = 0;
    end else if (!m_busy) begin
      if (model_hit(pc)) begin
        m_hits++;
        if (invalidate) m_valid = 0;
      end else begin
        m_busy = 1; m_fill_base = pc & LINE_MASK; m_got = 0; m_flush = 0; m_valid = 0;
        m_misses++;
      end
    end else begin
      if (invalidate) m_flush = 1;
      if (mem_ack) begin
        m_words[m_got] = DATA_TAG | (m_fill_base + 32'(4 * m_got));
        m_got++;
        if (m_got == LW) begin
          m_busy = 0; m_valid = !m_flush; m_line_base = m_fill_base;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      bit h;
      h = model_hit(pc);
      check("instr_valid", instr_valid, 32'(h));
      check("fetchstall", fetchstall, 32'(!h));
      check("instrdata", instrdata, h ? m_words[pc[3:2]] : NOP);
      check("mem_req", mem_req, 32'(m_busy));
      if (m_busy) check("mem_addr", mem_addr, m_fill_base + 32'(4 * m_got));
`ifdef FETCH_PERF_COUNT_EN
      check("hit_count", hit_count, m_hits);
      check("miss_count", miss_count, m_misses);
`endif
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; pc = 32'h0; mem_ack = 1; invalidate = 0;
    repeat (2) @(posedge clk);
    mid();
    check("rst_valid", instr_valid, 0);
    check("rst_stall", fetchstall, 1);
    check("rst_data", instrdata, NOP);
    check("rst_req", mem_req, 0);
    check("rst_addr", mem_addr, 0);
    cmp_en = 1;
    nxt(); reset = 0;

    // Cold miss on line 0 with ack always high.
    for (int i = 0; i < 5; i++) begin
      mid();
      check("s1_stall", fetchstall, 1);
      check("s1_nop", instrdata, NOP);
      if (i > 0) check("s1_addr", mem_addr, 32'(4 * (i - 1)));
      nxt();
    end
    mid();
    check("s1_hit_valid", instr_valid, 1);
    check("s1_hit_data", instrdata, 32'hA000_0000);

    // Sequential hits within the line.
    for (int i = 1; i < 4; i++) begin
      nxt(); pc = 32'(4 * i);
      mid();
      check("s2_data", instrdata, 32'hA000_0000 | 32'(4 * i));
      check("s2_stall", fetchstall, 0);
      check("s2_req", mem_req, 0);
    end

    // Miss on 0x10 with ack toggling.
    nxt(); pc = 32'h10; mem_ack = 0;
    mid();
`ifdef FETCH_PERF_COUNT_EN
    check("perf_hits", hit_count, 4);
    check("perf_misses", miss_count, 1);
`endif
    nxt();
    for (int f = 1; f <= 7; f++) begin
      mem_ack = (f % 2) == 1;
      mid();
      check("s3_addr", mem_addr, 32'h10 + 32'(4 * (f / 2)));
      check("s3_req", mem_req, 1);
      nxt();
    end
    mem_ack = 1;
    mid();
    check("s3_hit_valid", instr_valid, 1);
    check("s3_hit_data", instrdata, 32'hA000_0010);

    // Invalidate during the 0x20 fill forces an immediate refill.
    nxt(); pc = 32'h20;
    mid(); nxt();
    mid(); nxt(); invalidate = 1;
    mid(); nxt(); invalidate = 0;
    mid(); nxt();
    mid(); nxt();
    mid();
    check("s4_reissue_miss", instr_valid, 0);
    nxt();
    mid();
    check("s4_refill_addr", mem_addr, 32'h20);
    check("s4_refill_req", mem_req, 1);
    nxt();
    repeat (3) begin mid(); nxt(); end
    mid();
    check("s4_hit_valid", instr_valid, 1);
    check("s4_hit_data", instrdata, 32'hA000_0020);

    // Reset on the 3rd fill cycle of line 0x30; line 0x20 must miss afterwards.
    nxt(); pc = 32'h30;
    mid(); nxt();
    mid(); nxt();
    mid(); nxt(); reset = 1;
    mid(); nxt(); reset = 0; pc = 32'h20;
    mid();
    check("s5_req", mem_req, 0);
    check("s5_valid", instr_valid, 0);
    nxt();
    repeat (4) begin mid(); nxt(); end
    mid();
    check("s5_hit_valid", instr_valid, 1);
    check("s5_hit_data", instrdata, 32'hA000_0020);
    nxt();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
